// File: rtl/data_mem_ctrl.sv
// Data-memory responder: word RAM with byte/half/word loads and stores, sub-word stores by read-modify-write.
// Optional DATA_MEM_MISALIGN_TRAP_EN: misaligned LH/LHU/SH/LW/SW complete with o_Err instead of being force-aligned.
module data_mem_ctrl #(
    parameter int          ADDR_W      = 10,
    parameter logic [31:0] RESET_RDATA = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_Mem_Read,
    input  logic        i_Mem_Write,
    input  logic [2:0]  iv_Funct3,
    input  logic [31:0] iv_Addr,
    input  logic [31:0] iv_WData,
    output logic        o_Busy,
    output logic        o_RValid,
    output logic [31:0] ov_RData,
    output logic        o_WDone,
    output logic        o_Err
);
    localparam int AW = ADDR_W + 2;

    typedef enum logic [2:0] {IDLE, RD, MERGE, WR, RESP} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [2:0]    f3_q, f3_d;
    logic          is_wr_q, is_wr_d;
    logic          err_q, err_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          rvalid_q, rvalid_d;
    logic          wdone_q, wdone_d;
    logic          oerr_q, oerr_d;

    logic [31:0]   mem [0:(1<<ADDR_W)-1];
    logic [31:0]   rword_q;
    logic [ADDR_W-1:0] rd_idx;
    logic          we;
    logic          mis;
    logic          req_err;
    logic [31:0]   lane_b, lane_h, ld_val, merged;
    logic          unused_addr_bits;

    assign unused_addr_bits = &{1'b0, iv_Addr[31:AW]};

`ifdef DATA_MEM_MISALIGN_TRAP_EN
    assign mis = (iv_Funct3[1:0] == 2'b01 && iv_Addr[0]) ||
                 (iv_Funct3[1:0] == 2'b10 && iv_Addr[1:0] != 2'b00);
`else
    assign mis = 1'b0;
`endif

    assign req_err = mis | (i_Mem_Write ? (iv_Funct3 > 3'b010)
                                        : (iv_Funct3 == 3'b011 || iv_Funct3[2:1] == 2'b11));

    // The RAM read is launched on the accepting edge so the word is ready during RD.
    assign rd_idx = (state_q == IDLE) ? iv_Addr[AW-1:2] : addr_q[AW-1:2];
    assign we     = (state_q == WR) && !err_q && i_rst_n;

    always_ff @(posedge i_clk) begin
        if (we) mem[addr_q[AW-1:2]] <= wdata_q;
        rword_q <= mem[rd_idx];
    end

    always_comb begin
        lane_b = rword_q >> {addr_q[1:0], 3'b000};
        lane_h = rword_q >> {addr_q[1], 4'b0000};
        case (f3_q)
            3'b000:  ld_val = {{24{lane_b[7]}}, lane_b[7:0]};
            3'b001:  ld_val = {{16{lane_h[15]}}, lane_h[15:0]};
            3'b010:  ld_val = rword_q;
            3'b100:  ld_val = {24'h0, lane_b[7:0]};
            3'b101:  ld_val = {16'h0, lane_h[15:0]};
            default: ld_val = RESET_RDATA;
        endcase
        merged = rword_q;
        if (!f3_q[0]) merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
        else          merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        f3_d     = f3_q;
        is_wr_d  = is_wr_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        wdone_d  = 1'b0;
        oerr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_Mem_Read || i_Mem_Write) begin
                    addr_d  = iv_Addr[AW-1:0];
                    wdata_d = iv_WData;
                    f3_d    = iv_Funct3;
                    is_wr_d = i_Mem_Write;
                    err_d   = req_err;
                    // SB/SH need the old word; SW and illegal stores write (or skip) directly.
                    if (i_Mem_Write && iv_Funct3[2:1] != 2'b00) state_d = WR;
                    else                                        state_d = RD;
                end
            end
            RD: begin
                if (is_wr_q) begin
                    state_d = MERGE;
                end else begin
                    rdata_d  = err_q ? RESET_RDATA : ld_val;
                    rvalid_d = 1'b1;
                    oerr_d   = err_q;
                    state_d  = RESP;
                end
            end
            MERGE: begin
                wdata_d = merged;
                state_d = WR;
            end
            WR: begin
                wdone_d = 1'b1;
                oerr_d  = err_q;
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            f3_q     <= '0;
            is_wr_q  <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= RESET_RDATA;
            rvalid_q <= 1'b0;
            wdone_q  <= 1'b0;
            oerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            f3_q     <= f3_d;
            is_wr_q  <= is_wr_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            wdone_q  <= wdone_d;
            oerr_q   <= oerr_d;
        end
    end

    assign o_Busy   = (state_q != IDLE);
    assign o_RValid = rvalid_q;
    assign o_WDone  = wdone_q;
    assign o_Err    = oerr_q;
    assign ov_RData = rdata_q;
endmodule
